// File: rtl/axi4l_wb_bridge_if.sv
// Bus bundles for axi4l_wb_bridge: AXI4-Lite channels (axi4l_if) and
// Wishbone classic signals (wb_if), each with master and slave views.
interface axi4l_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int STRB_W = DATA_WIDTH / 8;

  logic [ADDR_WIDTH-1:0] s_aw_addr;
  logic                  s_aw_valid;
  logic                  s_aw_ready;
  logic [DATA_WIDTH-1:0] s_w_data;
  logic [STRB_W-1:0]     s_w_strb;
  logic                  s_w_valid;
  logic                  s_w_ready;
  logic [1:0]            s_b_resp;
  logic                  s_b_valid;
  logic                  s_b_ready;
  logic [ADDR_WIDTH-1:0] s_ar_addr;
  logic                  s_ar_valid;
  logic                  s_ar_ready;
  logic [DATA_WIDTH-1:0] s_r_data;
  logic [1:0]            s_r_resp;
  logic                  s_r_valid;
  logic                  s_r_ready;

  modport master (
    output s_aw_addr, s_aw_valid, input s_aw_ready,
    output s_w_data, s_w_strb, s_w_valid, input s_w_ready,
    input s_b_resp, s_b_valid, output s_b_ready,
    output s_ar_addr, s_ar_valid, input s_ar_ready,
    input s_r_data, s_r_resp, s_r_valid, output s_r_ready
  );

  modport slave (
    input s_aw_addr, s_aw_valid, output s_aw_ready,
    input s_w_data, s_w_strb, s_w_valid, output s_w_ready,
    output s_b_resp, s_b_valid, input s_b_ready,
    input s_ar_addr, s_ar_valid, output s_ar_ready,
    output s_r_data, s_r_resp, s_r_valid, input s_r_ready
  );
endinterface

interface wb_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int STRB_W = DATA_WIDTH / 8;

  logic [ADDR_WIDTH-1:0] wb_adr_o;
  logic [DATA_WIDTH-1:0] wb_dat_o;
  logic [STRB_W-1:0]     wb_sel_o;
  logic                  wb_we_o;
  logic                  wb_cyc_o;
  logic                  wb_stb_o;
  logic [DATA_WIDTH-1:0] wb_dat_i;
  logic                  wb_ack_i;
  logic                  wb_err_i;

  modport master (
    output wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o,
    input  wb_dat_i, wb_ack_i, wb_err_i
  );

  modport slave (
    input  wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o,
    output wb_dat_i, wb_ack_i, wb_err_i
  );
endinterface

// File: rtl/axi4l_wb_bridge.sv
// AXI4-Lite slave to Wishbone classic master bridge, one transaction at a time.
// Define AXI4L_WB_BRIDGE_TIMEOUT_EN to add the Wishbone bus-timeout watchdog.
module axi4l_wb_bridge #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  axi4l_if.slave   s_axi,
  wb_if.master     wb
);

  if ((DATA_WIDTH != 32 && DATA_WIDTH != 64) || ADDR_WIDTH < 1 ||
      TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_param_check
    $error("axi4l_wb_bridge: illegal parameter value");
  end

  typedef enum logic [2:0] {
    IDLE,
    WB_WR,
    WB_RD,
    B_RESP,
    R_RESP
  } state_t;

  state_t state;
  logic   last_was_write;
  logic   wr_eligible;
  logic   rd_eligible;
  logic   grant_wr;
  logic   grant_rd;
  logic   in_bus_cycle;
  logic   timed_out;
  logic   bus_done;
  logic   bus_fail;

  // When both directions are eligible, the one not served last wins.
  always_comb begin
    wr_eligible = s_axi.s_aw_valid && s_axi.s_w_valid;
    rd_eligible = s_axi.s_ar_valid;
    grant_wr    = (state == IDLE) && wr_eligible && (!rd_eligible || !last_was_write);
    grant_rd    = (state == IDLE) && rd_eligible && (!wr_eligible || last_was_write);
  end

  assign s_axi.s_aw_ready = grant_wr;
  assign s_axi.s_w_ready  = grant_wr;
  assign s_axi.s_ar_ready = grant_rd;
  assign in_bus_cycle     = (state == WB_WR) || (state == WB_RD);

`ifdef AXI4L_WB_BRIDGE_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);

  logic [15:0] wait_cnt;

  // An ack or err landing on the matching cycle still completes normally.
  assign timed_out = (wait_cnt == TIMEOUT_LIMIT) && !wb.wb_ack_i && !wb.wb_err_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wait_cnt <= '0;
    end else if (!in_bus_cycle) begin
      wait_cnt <= '0;
    end else if (!wb.wb_ack_i && !wb.wb_err_i) begin
      wait_cnt <= wait_cnt + 16'd1;
    end
  end
`else
  assign timed_out = 1'b0;
`endif

  assign bus_done = wb.wb_ack_i || wb.wb_err_i || timed_out;
  assign bus_fail = wb.wb_err_i || timed_out;

  // Main sequencer; every bus-facing output except the grant readies is registered here.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state            <= IDLE;
      last_was_write   <= 1'b0;
      wb.wb_adr_o      <= '0;
      wb.wb_dat_o      <= '0;
      wb.wb_sel_o      <= '0;
      wb.wb_we_o       <= 1'b0;
      wb.wb_cyc_o      <= 1'b0;
      wb.wb_stb_o      <= 1'b0;
      s_axi.s_b_resp   <= 2'b00;
      s_axi.s_b_valid  <= 1'b0;
      s_axi.s_r_data   <= '0;
      s_axi.s_r_resp   <= 2'b00;
      s_axi.s_r_valid  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (grant_wr) begin
            wb.wb_adr_o    <= s_axi.s_aw_addr;
            wb.wb_dat_o    <= s_axi.s_w_data;
            wb.wb_sel_o    <= s_axi.s_w_strb;
            wb.wb_we_o     <= 1'b1;
            wb.wb_cyc_o    <= 1'b1;
            wb.wb_stb_o    <= 1'b1;
            last_was_write <= 1'b1;
            state          <= WB_WR;
          end else if (grant_rd) begin
            wb.wb_adr_o    <= s_axi.s_ar_addr;
            wb.wb_sel_o    <= '1;
            wb.wb_we_o     <= 1'b0;
            wb.wb_cyc_o    <= 1'b1;
            wb.wb_stb_o    <= 1'b1;
            last_was_write <= 1'b0;
            state          <= WB_RD;
          end
        end

        WB_WR: begin
          if (bus_done) begin
            wb.wb_cyc_o     <= 1'b0;
            wb.wb_stb_o     <= 1'b0;
            wb.wb_we_o      <= 1'b0;
            s_axi.s_b_resp  <= bus_fail ? 2'b10 : 2'b00;
            s_axi.s_b_valid <= 1'b1;
            state           <= B_RESP;
          end
        end

        WB_RD: begin
          if (bus_done) begin
            wb.wb_cyc_o     <= 1'b0;
            wb.wb_stb_o     <= 1'b0;
            s_axi.s_r_data  <= bus_fail ? '0 : wb.wb_dat_i;
            s_axi.s_r_resp  <= bus_fail ? 2'b10 : 2'b00;
            s_axi.s_r_valid <= 1'b1;
            state           <= R_RESP;
          end
        end

        B_RESP: begin
          if (s_axi.s_b_ready) begin
            s_axi.s_b_valid <= 1'b0;
            state           <= IDLE;
          end
        end

        R_RESP: begin
          if (s_axi.s_r_ready) begin
            s_axi.s_r_valid <= 1'b0;
            state           <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi4l_wb_bridge.sv
// Randomised self-checking bench for axi4l_wb_bridge against a transaction-level model
// (word memory, fair-arbitration flag, expected latency); honours AXI4L_WB_BRIDGE_TIMEOUT_EN.
module tb_axi4l_wb_bridge;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
`ifdef AXI4L_WB_BRIDGE_TIMEOUT_EN
  localparam int TO    = 8;
  localparam bit TO_ON = 1'b1;
`else
  localparam int TO    = 255;
  localparam bit TO_ON = 1'b0;
`endif

  logic clk_i;
  logic rst_ni;

  axi4l_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) axi ();
  wb_if    #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) wb ();

  axi4l_wb_bridge #(
    .ADDR_WIDTH    (AW),
    .DATA_WIDTH    (DW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .s_axi (axi),
    .wb    (wb)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int vectors;
  int miscompares;

  logic [DW-1:0] ref_mem   [16];
  logic [DW-1:0] slave_mem [16];
  bit            model_last_w;
  logic [DW-1:0] model_wdata;

  logic [AW-1:0] w_addr;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] w_data;
  logic [SW-1:0] w_strb;
  int            slave_delay;
  bit            slave_err;
  bit            slave_err_ack;
  int            rdy_hold;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic finish_run();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Wishbone slave: responds slave_delay cycles after the cycle starts.
  initial begin
    int wait_cnt;
    int idx;
    wait_cnt    = 0;
    wb.wb_ack_i = 1'b0;
    wb.wb_err_i = 1'b0;
    wb.wb_dat_i = '0;
    forever begin
      @(negedge clk_i);
      wb.wb_ack_i = 1'b0;
      wb.wb_err_i = 1'b0;
      if (wb.wb_cyc_o && wb.wb_stb_o) begin
        if (wait_cnt >= slave_delay) begin
          wait_cnt = 0;
          idx = int'(wb.wb_adr_o[5:2]);
          if (slave_err) begin
            wb.wb_err_i = 1'b1;
            wb.wb_ack_i = slave_err_ack;
            wb.wb_dat_i = $urandom;
          end else begin
            wb.wb_ack_i = 1'b1;
            if (wb.wb_we_o) begin
              for (int b = 0; b < SW; b++)
                if (wb.wb_sel_o[b]) slave_mem[idx][8*b +: 8] = wb.wb_dat_o[8*b +: 8];
            end else begin
              wb.wb_dat_i = slave_mem[idx];
            end
          end
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // Presents the requested AXI traffic and checks every grant, bus cycle and response.
  task automatic applyStimulus(input bit do_w, input bit do_r);
    bit            pend_w;
    bit            pend_r;
    bit            gw;
    bit            seen;
    bit            exp_fail;
    bit            vld;
    int            lat;
    int            exp_lat;
    int            widx;
    logic [DW-1:0] exp_rdata;
    logic [1:0]    exp_resp;
    pend_w = do_w;
    pend_r = do_r;
    @(negedge clk_i);
    axi.s_aw_addr  = w_addr;
    axi.s_w_data   = w_data;
    axi.s_w_strb   = w_strb;
    axi.s_aw_valid = do_w;
    axi.s_w_valid  = do_w;
    axi.s_ar_addr  = r_addr;
    axi.s_ar_valid = do_r;
    while (pend_w || pend_r) begin
      gw   = pend_w && (!pend_r || !model_last_w);
      lat  = 0;
      seen = 1'b0;
      while (!seen && lat < 50) begin
        #1;
        if (gw ? (axi.s_aw_ready && axi.s_w_ready) : axi.s_ar_ready) seen = 1'b1;
        else begin
          @(negedge clk_i);
          lat++;
        end
      end
      checkOutput(gw ? "write_grant" : "read_grant", 64'(seen), 64'd1);
      if (!seen) finish_run();
      checkOutput("other_ready_low", 64'(gw ? axi.s_ar_ready : axi.s_aw_ready), 64'd0);
      model_last_w = gw;
      exp_fail = slave_err || (TO_ON && slave_delay > TO);
      exp_lat  = ((TO_ON && slave_delay > TO) ? TO : slave_delay) + 2;

      @(negedge clk_i);
      if (gw) begin
        axi.s_aw_valid = 1'b0;
        axi.s_w_valid  = 1'b0;
        pend_w         = 1'b0;
        model_wdata    = w_data;
      end else begin
        axi.s_ar_valid = 1'b0;
        pend_r         = 1'b0;
      end
      #1;
      checkOutput("wb_cyc_stb", 64'({wb.wb_cyc_o, wb.wb_stb_o}), 64'd3);
      checkOutput("wb_we", 64'(wb.wb_we_o), 64'(gw));
      checkOutput("wb_adr", 64'(wb.wb_adr_o), 64'(gw ? w_addr : r_addr));
      checkOutput("wb_sel", 64'(wb.wb_sel_o), 64'(gw ? w_strb : {SW{1'b1}}));
      checkOutput("wb_dat_o", 64'(wb.wb_dat_o), 64'(model_wdata));

      lat = 1;
      do begin
        @(negedge clk_i);
        #1;
        lat++;
        vld = gw ? axi.s_b_valid : axi.s_r_valid;
      end while (!vld && lat < 300);
      checkOutput("resp_latency", 64'(lat), 64'(exp_lat));
      if (!vld) finish_run();
      checkOutput("wb_cyc_dropped", 64'({wb.wb_cyc_o, wb.wb_stb_o}), 64'd0);

      exp_resp  = exp_fail ? 2'b10 : 2'b00;
      exp_rdata = '0;
      if (gw) begin
        if (!exp_fail) begin
          widx = int'(w_addr[5:2]);
          for (int b = 0; b < SW; b++)
            if (w_strb[b]) ref_mem[widx][8*b +: 8] = w_data[8*b +: 8];
        end
      end else begin
        exp_rdata = exp_fail ? '0 : ref_mem[int'(r_addr[5:2])];
      end

      for (int h = 0; h <= rdy_hold; h++) begin
        if (h > 0) begin
          @(negedge clk_i);
          #1;
        end
        if (gw) begin
          checkOutput("b_valid_held", 64'(axi.s_b_valid), 64'd1);
          checkOutput("b_resp", 64'(axi.s_b_resp), 64'(exp_resp));
        end else begin
          checkOutput("r_valid_held", 64'(axi.s_r_valid), 64'd1);
          checkOutput("r_resp", 64'(axi.s_r_resp), 64'(exp_resp));
          checkOutput("r_data", 64'(axi.s_r_data), 64'(exp_rdata));
        end
      end
      if (gw) axi.s_b_ready = 1'b1;
      else    axi.s_r_ready = 1'b1;
      @(negedge clk_i);
      axi.s_b_ready = 1'b0;
      axi.s_r_ready = 1'b0;
      #1;
      checkOutput("valid_cleared", 64'(gw ? axi.s_b_valid : axi.s_r_valid), 64'd0);
    end
  endtask

  initial begin
    vectors       = 0;
    miscompares   = 0;
    model_last_w  = 1'b0;
    model_wdata   = '0;
    for (int i = 0; i < 16; i++) begin
      ref_mem[i]   = $urandom;
      slave_mem[i] = ref_mem[i];
    end
    ref_mem[5]    = 32'h1234_5678;
    slave_mem[5]  = 32'h1234_5678;
    axi.s_aw_addr  = '0;
    axi.s_aw_valid = 1'b0;
    axi.s_w_data   = '0;
    axi.s_w_strb   = '0;
    axi.s_w_valid  = 1'b0;
    axi.s_b_ready  = 1'b0;
    axi.s_ar_addr  = '0;
    axi.s_ar_valid = 1'b0;
    axi.s_r_ready  = 1'b0;
    slave_delay    = 0;
    slave_err      = 1'b0;
    slave_err_ack  = 1'b0;
    rdy_hold       = 0;
    rst_ni         = 1'b0;

    repeat (3) @(negedge clk_i);
    #1;
    checkOutput("rst_ready_valid", 64'({axi.s_aw_ready, axi.s_w_ready, axi.s_ar_ready,
                                        axi.s_b_valid, axi.s_r_valid}), 64'd0);
    checkOutput("rst_resp", 64'({axi.s_b_resp, axi.s_r_resp}), 64'd0);
    checkOutput("rst_r_data", 64'(axi.s_r_data), 64'd0);
    checkOutput("rst_wb_ctl", 64'({wb.wb_cyc_o, wb.wb_stb_o, wb.wb_we_o}), 64'd0);
    checkOutput("rst_wb_bus", 64'({wb.wb_adr_o, wb.wb_dat_o, wb.wb_sel_o}), 64'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    $display("[TB] contention from reset: write then read");
    w_addr = 32'h20; w_data = $urandom; w_strb = 4'hF; r_addr = 32'h24;
    applyStimulus(1'b1, 1'b1);
    w_addr = 32'h28; w_data = $urandom; w_strb = 4'h5;
    applyStimulus(1'b1, 1'b0);
    r_addr = 32'h28; w_addr = 32'h2C; w_data = $urandom; w_strb = 4'hF;
    applyStimulus(1'b1, 1'b1);

    $display("[TB] single write and held read");
    w_addr = 32'h10; w_data = 32'hDEAD_BEEF; w_strb = 4'hF;
    applyStimulus(1'b1, 1'b0);
    r_addr = 32'h14; rdy_hold = 5;
    applyStimulus(1'b0, 1'b1);
    rdy_hold = 0;

    $display("[TB] wishbone error with ack");
    slave_err = 1'b1; slave_err_ack = 1'b1;
    r_addr = 32'h10;
    applyStimulus(1'b0, 1'b1);
    w_addr = 32'h18; w_data = $urandom; w_strb = 4'hF;
    applyStimulus(1'b1, 1'b0);
    slave_err = 1'b0; slave_err_ack = 1'b0;
    r_addr = 32'h18;
    applyStimulus(1'b0, 1'b1);

    $display("[TB] slow or silent slave");
    slave_delay = 100; r_addr = 32'h10;
    applyStimulus(1'b0, 1'b1);
    if (TO_ON) begin
      slave_delay = TO;
      applyStimulus(1'b0, 1'b1);
      slave_delay = TO + 1; w_addr = 32'h1C; w_data = $urandom; w_strb = 4'hF;
      applyStimulus(1'b1, 1'b0);
    end

    $display("[TB] reset during a bus cycle");
    slave_delay = 100;
    @(negedge clk_i);
    axi.s_aw_addr = 32'h30; axi.s_w_data = 32'hCAFE_F00D; axi.s_w_strb = 4'hF;
    axi.s_aw_valid = 1'b1; axi.s_w_valid = 1'b1;
    #1;
    checkOutput("rst_test_grant", 64'(axi.s_aw_ready), 64'd1);
    @(negedge clk_i);
    axi.s_aw_valid = 1'b0; axi.s_w_valid = 1'b0;
    #1;
    checkOutput("rst_test_cyc_high", 64'(wb.wb_cyc_o), 64'd1);
    #1;
    rst_ni = 1'b0;
    #1;
    checkOutput("rst_async_wb", 64'({wb.wb_cyc_o, wb.wb_stb_o, wb.wb_we_o}), 64'd0);
    checkOutput("rst_async_valid", 64'({axi.s_b_valid, axi.s_r_valid, axi.s_aw_ready,
                                        axi.s_w_ready, axi.s_ar_ready}), 64'd0);
    checkOutput("rst_async_dat_o", 64'(wb.wb_dat_o), 64'd0);
    @(negedge clk_i);
    rst_ni       = 1'b1;
    model_last_w = 1'b0;
    model_wdata  = '0;
    slave_delay  = 0;
    w_addr = 32'h30; w_data = 32'h0BAD_F00D; w_strb = 4'hF; r_addr = 32'h30;
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1);

    $display("[TB] randomised traffic");
    for (int n = 0; n < 40; n++) begin
      int mode;
      mode          = $urandom_range(0, 2);
      w_addr        = 32'($urandom_range(0, 15)) << 2;
      r_addr        = 32'($urandom_range(0, 15)) << 2;
      w_data        = $urandom;
      w_strb        = 4'($urandom_range(0, 15));
      slave_delay   = $urandom_range(0, 3);
      slave_err     = ($urandom_range(0, 7) == 0);
      slave_err_ack = 1'($urandom_range(0, 1));
      rdy_hold      = $urandom_range(0, 2);
      applyStimulus(mode != 1, mode != 0);
    end

    finish_run();
  end

endmodule
